bcd_seq_converter: RTL and testbench
====================================

// Module: bcd_seq_converter
// PURPOSE
//  Multi-cycle binary-to-BCD converter using shift-add-3 (double dabble).
//  Sits upstream of the 7-segment display mux and consumes the 0-255 event counter value.
//  Converts on request with a START/BUSY/DONE handshake.
//  Holds its digit outputs stable between conversions, so the display never shows intermediate values.
// PARAMETERS
//  WIDTH   8  binary input width in bits (>=1)
//  DIGITS  3  number of BCD digits produced (>=1)
// PORTS
//  CLKIN     in   1          clock; all state changes on rising edge
//  RESET     in   1          synchronous, active-high reset
//  START     in   1          request conversion of BIN; sampled only in IDLE
//  BIN       in   WIDTH      binary value; captured on the edge that accepts START
//  BUSY      out  1          high while a conversion is in progress
//  DONE      out  1          single-cycle pulse when BCD/OVERFLOW are updated
//  BCD       out  4*DIGITS   result digits; digit k at [4k+3:4k] (k=0 is ones)
//  OVERFLOW  out  1          result truncated: BIN > 10^DIGITS-1
// BEHAVIOUR
//  Reset (RESET=1 at an edge): state=IDLE, BUSY=0, DONE=0, BCD=0, OVERFLOW=0.
//  - Reset applies in any state.
//  - A conversion in progress is aborted and produces no DONE.
//  FSM, two states: IDLE, SHIFT.
//  IDLE, START=1 at edge E0:
//  - Latch BIN into the shift register.
//  - Clear the scratch digits and the internal overflow flag.
//  - Load bit counter = WIDTH; go to SHIFT; BUSY=1.
//  IDLE, START=0: hold everything; DONE=0.
//  SHIFT, at each edge:
//  - In every scratch digit with value >=5, add 3 (4-bit, no carry out).
//  - Shift {scratch digits, shift reg} left by 1.
//  - Bit shifted out of the top digit =1 -> set the internal overflow flag (sticky).
//  - Decrement the counter.
//  SHIFT, edge E_WIDTH (counter reaches 0):
//  - BCD <= final scratch digits; OVERFLOW <= overflow flag.
//  - DONE=1 for exactly the following cycle; BUSY=0; state=IDLE.
//  Latency: START accepted at E0 -> BUSY high from E0 to E_WIDTH -> DONE high after E_WIDTH.
//  - Default: 8 cycles from acceptance to result.
//  Result: BCD = BIN mod 10^DIGITS, each digit 0..9; OVERFLOW=1 iff BIN >= 10^DIGITS.
//  - With the defaults, OVERFLOW is always 0 (255 < 1000).
//  START while BUSY=1: ignored, no queuing; BIN changes during a conversion have no effect.
//  START=1 in the DONE cycle: accepted (state is IDLE); the next conversion starts back-to-back.
//  - DONE stays a single pulse.
//  BCD/OVERFLOW change only on DONE edges or reset; they hold the previous result during SHIFT.
//  START held high continuously: a new conversion is accepted every WIDTH+1 cycles.
//  Counter width: $clog2(WIDTH+1) bits.
//  Scratch digits: exactly 4*DIGITS bits; no wider intermediate is exposed.
// TESTING
//  1. RESET pulse -> BCD=0, OVERFLOW=0, BUSY=0, DONE=0; START=1, BIN=0 -> DONE after 8 edges, BCD=12'h000.
//  2. BIN=8'd255, START=1 for one cycle -> BUSY high 8 cycles, one DONE pulse, BCD=12'h255, OVERFLOW=0.
//  3. BIN=99 then, in the DONE cycle, START with BIN=100 -> DONEs 9 cycles apart; BCD=12'h099 then 12'h100.
//  4. BIN=37 accepted, then START with BIN=200 at cycle 3 -> second START ignored; BCD=12'h037; single DONE.
//  5. BIN=180 accepted, RESET at cycle 4 -> BUSY=0, no DONE, BCD=0; a new START with BIN=7 -> BCD=12'h007.
//  6. WIDTH=10, DIGITS=3: BIN=1023 -> BCD=12'h023, OVERFLOW=1; then BIN=999 -> BCD=12'h999, OVERFLOW=0.

Source files
------------

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (shift-add-3 / double dabble) with a
// START/BUSY/DONE handshake; results are held stable between conversions.
module bcd_seq_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  CLKIN,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [WIDTH-1:0]      BIN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  OVERFLOW
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [WIDTH-1:0]   shift_reg;
    logic [BCD_W-1:0]   scratch;
    logic               ovf_flag;
    logic [CNT_W-1:0]   cnt;
    logic               done_q;

    logic [BCD_W-1:0]   adjusted;
    logic [BCD_W-1:0]   shifted_scratch;
    logic [WIDTH-1:0]   shifted_bin;
    logic               carry_out;
    logic               last_shift;

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (START)      next_state = SHIFT;
            SHIFT:   if (last_shift) next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    always_comb begin
        BUSY = (state == SHIFT);
        DONE = done_q;
    end

    // Add-3 correction on every digit before the shift; 4-bit wrap is intended.
    always_comb begin
        adjusted = scratch;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch[4*k +: 4] >= 4'd5) begin
                adjusted[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            end
        end
    end

    // A bit leaving the top digit means the value has reached 10^DIGITS.
    assign {carry_out, shifted_scratch, shifted_bin} = {adjusted, shift_reg, 1'b0};
    assign last_shift = (cnt == CNT_W'(1));

    always_ff @(posedge CLKIN) begin
        if (RESET) begin
            shift_reg <= '0;
            scratch   <= '0;
            ovf_flag  <= 1'b0;
            cnt       <= '0;
            done_q    <= 1'b0;
            BCD       <= '0;
            OVERFLOW  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        shift_reg <= BIN;
                        scratch   <= '0;
                        ovf_flag  <= 1'b0;
                        cnt       <= CNT_W'(WIDTH);
                    end
                end
                SHIFT: begin
                    shift_reg <= shifted_bin;
                    scratch   <= shifted_scratch;
                    ovf_flag  <= ovf_flag | carry_out;
                    cnt       <= cnt - CNT_W'(1);
                    if (last_shift) begin
                        BCD      <= shifted_scratch;
                        OVERFLOW <= ovf_flag | carry_out;
                        done_q   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Self-checking bench for bcd_seq_converter: vector table, handshake corner
// cases, and randomized values compared against an arithmetic reference.
module tb_bcd_seq_converter;

    logic        CLKIN = 1'b0;
    logic        RESET;
    logic        START;
    logic [7:0]  BIN;
    logic        BUSY;
    logic        DONE;
    logic [11:0] BCD;
    logic        OVERFLOW;

    logic        start10;
    logic [9:0]  bin10;
    logic        busy10;
    logic        done10;
    logic [11:0] bcd10;
    logic        ovf10;

    int checks = 0;
    int errors = 0;

    bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) dut (
        .CLKIN(CLKIN), .RESET(RESET), .START(START), .BIN(BIN),
        .BUSY(BUSY), .DONE(DONE), .BCD(BCD), .OVERFLOW(OVERFLOW)
    );

    bcd_seq_converter #(.WIDTH(10), .DIGITS(3)) dut10 (
        .CLKIN(CLKIN), .RESET(RESET), .START(start10), .BIN(bin10),
        .BUSY(busy10), .DONE(done10), .BCD(bcd10), .OVERFLOW(ovf10)
    );

    always #5 CLKIN = ~CLKIN;

    typedef struct {
        logic [7:0]  bin;
        logic [11:0] bcd;
        logic        ovf;
    } vec_t;

    // Decimal digits of v, ones digit in the lowest nibble.
    function automatic logic [11:0] ref_bcd(input int v);
        logic [11:0] r = '0;
        int x = v;
        for (int k = 0; k < 3; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int v);
        return v >= 1000;
    endfunction

    task automatic step();
        @(posedge CLKIN);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Pulse START for one cycle, scramble BIN during the conversion, wait for DONE.
    task automatic applyStimulus(input logic [7:0] b, output logic [11:0] bcd, output logic ovf,
                                 output int lat, output logic busy0, output logic hold_ok);
        logic [11:0] prev;
        logic        prev_ovf;
        prev     = BCD;
        prev_ovf = OVERFLOW;
        BIN      = b;
        START    = 1'b1;
        step();
        START    = 1'b0;
        BIN      = ~b;
        busy0    = BUSY;
        lat      = 0;
        hold_ok  = 1'b1;
        while (!DONE && lat < 20) begin
            if (BCD !== prev || OVERFLOW !== prev_ovf) hold_ok = 1'b0;
            step();
            lat++;
        end
        bcd = BCD;
        ovf = OVERFLOW;
    endtask

    task automatic applyStimulus10(input logic [9:0] b, output logic [11:0] bcd, output logic ovf,
                                   output int lat);
        bin10   = b;
        start10 = 1'b1;
        step();
        start10 = 1'b0;
        bin10   = ~b;
        lat     = 0;
        while (!done10 && lat < 20) begin
            step();
            lat++;
        end
        bcd = bcd10;
        ovf = ovf10;
    endtask

    initial begin
        vec_t        vecs[10];
        logic [11:0] got_bcd;
        logic        got_ovf;
        logic        busy0;
        logic        hold_ok;
        int          lat;
        int          ndone;
        int          done_at;
        int          last_done;
        int          bad_gap;
        int          v;

        vecs[0] = '{8'd0,   12'h000, 1'b0};
        vecs[1] = '{8'd255, 12'h255, 1'b0};
        vecs[2] = '{8'd99,  12'h099, 1'b0};
        vecs[3] = '{8'd100, 12'h100, 1'b0};
        vecs[4] = '{8'd37,  12'h037, 1'b0};
        vecs[5] = '{8'd9,   12'h009, 1'b0};
        vecs[6] = '{8'd10,  12'h010, 1'b0};
        vecs[7] = '{8'd128, 12'h128, 1'b0};
        vecs[8] = '{8'd199, 12'h199, 1'b0};
        vecs[9] = '{8'd64,  12'h064, 1'b0};

        RESET   = 1'b1;
        START   = 1'b0;
        BIN     = '0;
        start10 = 1'b0;
        bin10   = '0;
        step();
        step();
        RESET = 1'b0;
        checkOutput("reset_bcd",  BCD, 0);
        checkOutput("reset_ovf",  OVERFLOW, 0);
        checkOutput("reset_busy", BUSY, 0);
        checkOutput("reset_done", DONE, 0);
        checkOutput("reset_bcd10", bcd10, 0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].bin, got_bcd, got_ovf, lat, busy0, hold_ok);
            checkOutput($sformatf("vec%0d_bcd", i), got_bcd, vecs[i].bcd);
            checkOutput($sformatf("vec%0d_ovf", i), got_ovf, vecs[i].ovf);
            checkOutput($sformatf("vec%0d_latency", i), lat, 8);
            checkOutput($sformatf("vec%0d_busy", i), busy0, 1);
            checkOutput($sformatf("vec%0d_hold", i), hold_ok, 1);
            checkOutput($sformatf("vec%0d_busy_end", i), BUSY, 0);
        end

        // Back-to-back: START in the DONE cycle is accepted.
        applyStimulus(8'd99, got_bcd, got_ovf, lat, busy0, hold_ok);
        checkOutput("b2b_first_bcd", got_bcd, 12'h099);
        BIN   = 8'd100;
        START = 1'b1;
        step();
        START = 1'b0;
        checkOutput("b2b_done_single", DONE, 0);
        checkOutput("b2b_busy", BUSY, 1);
        lat = 1;
        while (!DONE && lat < 20) begin
            step();
            lat++;
        end
        checkOutput("b2b_gap", lat, 9);
        checkOutput("b2b_second_bcd", BCD, 12'h100);

        // START during a conversion is ignored.
        BIN   = 8'd37;
        START = 1'b1;
        step();
        START   = 1'b0;
        ndone   = 0;
        done_at = -1;
        for (int i = 1; i <= 20; i++) begin
            if (i == 3) begin
                BIN   = 8'd200;
                START = 1'b1;
            end
            step();
            START = 1'b0;
            if (DONE) begin
                ndone++;
                if (done_at < 0) done_at = i;
                if (ndone == 1) got_bcd = BCD;
            end
        end
        checkOutput("ignore_ndone", ndone, 1);
        checkOutput("ignore_done_at", done_at, 8);
        checkOutput("ignore_bcd", got_bcd, 12'h037);

        // Reset mid-conversion aborts without DONE and clears the result.
        BIN   = 8'd180;
        START = 1'b1;
        step();
        START = 1'b0;
        for (int i = 0; i < 3; i++) step();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        checkOutput("abort_busy", BUSY, 0);
        checkOutput("abort_bcd", BCD, 0);
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (DONE) ndone++;
            step();
        end
        checkOutput("abort_no_done", ndone, 0);
        applyStimulus(8'd7, got_bcd, got_ovf, lat, busy0, hold_ok);
        checkOutput("after_abort_bcd", got_bcd, 12'h007);
        checkOutput("after_abort_latency", lat, 8);

        // START held high: one result every WIDTH+1 cycles.
        BIN       = 8'd55;
        START     = 1'b1;
        ndone     = 0;
        last_done = -1;
        bad_gap   = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (DONE) begin
                if (last_done >= 0 && i - last_done != 9) bad_gap++;
                last_done = i;
                ndone++;
            end
        end
        START = 1'b0;
        checkOutput("cont_ndone", ndone, 4);
        checkOutput("cont_gap", bad_gap, 0);
        checkOutput("cont_bcd", BCD, 12'h055);
        for (int i = 0; i < 12; i++) step();

        for (int i = 0; i < 30; i++) begin
            v = int'($urandom_range(0, 255));
            applyStimulus(8'(v), got_bcd, got_ovf, lat, busy0, hold_ok);
            checkOutput($sformatf("rand%0d_bin%0d_bcd", i, v), got_bcd, ref_bcd(v));
            checkOutput($sformatf("rand%0d_bin%0d_ovf", i, v), got_ovf, ref_ovf(v));
            checkOutput($sformatf("rand%0d_latency", i), lat, 8);
            checkOutput($sformatf("rand%0d_hold", i), hold_ok, 1);
        end

        applyStimulus10(10'd1023, got_bcd, got_ovf, lat);
        checkOutput("w10_1023_bcd", got_bcd, 12'h023);
        checkOutput("w10_1023_ovf", got_ovf, 1);
        checkOutput("w10_latency", lat, 10);
        applyStimulus10(10'd999, got_bcd, got_ovf, lat);
        checkOutput("w10_999_bcd", got_bcd, 12'h999);
        checkOutput("w10_999_ovf", got_ovf, 0);
        applyStimulus10(10'd1000, got_bcd, got_ovf, lat);
        checkOutput("w10_1000_bcd", got_bcd, 12'h000);
        checkOutput("w10_1000_ovf", got_ovf, 1);

        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(0, 1023));
            applyStimulus10(10'(v), got_bcd, got_ovf, lat);
            checkOutput($sformatf("w10rand%0d_bin%0d_bcd", i, v), got_bcd, ref_bcd(v));
            checkOutput($sformatf("w10rand%0d_bin%0d_ovf", i, v), got_ovf, ref_ovf(v));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
